fb_access_scheduler: RTL

Sequences the single-port, double-banked frame memory between rasterizer pixel writes and DVI scan-out reads. It arbitrates one memory op per cycle and feeds the display FIFO. It owns the front/back bank swap, triggered by rast_done plus next_frame_switch, and clears the new back bank before drawing resumes. It sits between the rasterizer and the display FIFO, replacing the ad-hoc control inside frame_buffer.

---
 rtl/fb_pkg.sv | 34 +++
 rtl/fb_rr_arbiter.sv | 45 ++++
 rtl/fb_access_scheduler.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared types and widths for the frame-buffer access scheduler.
package fb_pkg;

  localparam int COLOR_W = 3;
  localparam int X_W     = 10;
  localparam int Y_W     = 9;

  // Scheduler phases for the back bank.
  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    DRAW      = 2'd1,
    DONE      = 2'd2,
    WAIT_SCAN = 2'd3
  } fb_state_e;

  // Which requester owns the memory port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_WR   = 2'd2
  } fb_gnt_e;

  // One-hot grant {wr, disp} to encoded grant.
  function automatic fb_gnt_e gnt_encode(input logic [1:0] gnt_oh);
    fb_gnt_e g;
    case (gnt_oh)
      2'b01:   g = GNT_DISP;
      2'b10:   g = GNT_WR;
      default: g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/fb_rr_arbiter.sv
// Two-requester round-robin arbiter (display read vs. writer).
// Grant is combinational; the last-grant flag is registered.
module fb_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_disp,
  input  logic       req_wr,
  output logic [1:0] gnt_oh   // bit0 = display, bit1 = writer
);

  logic last_wr_q;
  logic last_wr_d;

  // Pick a winner; on contention favour whoever did not win last time.
  always_comb begin
    gnt_oh    = 2'b00;
    last_wr_d = last_wr_q;
    if (req_disp && req_wr) begin
      gnt_oh = last_wr_q ? 2'b01 : 2'b10;
    end else if (req_disp) begin
      gnt_oh = 2'b01;
    end else if (req_wr) begin
      gnt_oh = 2'b10;
    end else begin
      gnt_oh = 2'b00;
    end
    if (gnt_oh[1]) begin
      last_wr_d = 1'b1;
    end else if (gnt_oh[0]) begin
      last_wr_d = 1'b0;
    end else begin
      last_wr_d = last_wr_q;
    end
  end

  // Remember the last winner; reset treats the display as last served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_wr_q <= 1'b0;
    end else begin
      last_wr_q <= last_wr_d;
    end
  end

endmodule

// File: rtl/fb_access_scheduler.sv
// Frame-buffer access scheduler: one memory op per cycle shared between
// scan-out reads of the front bank and clear/raster writes to the back bank,
// plus the front/back swap sequencing.
module fb_access_scheduler
  import fb_pkg::*;
#(
  parameter int                  H_RES       = 640,
  parameter int                  V_RES       = 480,
  parameter int                  ADDR_W      = 19,
  parameter logic [COLOR_W-1:0]  CLEAR_COLOR = 3'b000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rast_pixel_rdy,
  input  logic [COLOR_W-1:0]  rast_color_input,
  input  logic [X_W-1:0]      rast_width,
  input  logic [Y_W-1:0]      rast_height,
  input  logic                rast_done,
  output logic                read_rast_pixel_rdy,
  input  logic                next_frame_switch,
  input  logic                dvi_fifo_full,
  output logic [COLOR_W-1:0]  dvi_color_out,
  output logic                dvi_fifo_write_enable,
  output logic [ADDR_W:0]     mem_addr,
  output logic                mem_we,
  output logic [COLOR_W-1:0]  mem_wdata,
  input  logic [COLOR_W-1:0]  mem_rdata,
  output logic                front_buffer
);

  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [X_W-1:0]    H_LIM    = X_W'(H_RES);
  localparam logic [Y_W-1:0]    V_LIM    = Y_W'(V_RES);

  fb_state_e         state_q, state_d;
  logic              front_q, front_d;
  logic [ADDR_W-1:0] scan_q,  scan_d;
  logic [ADDR_W-1:0] clr_q,   clr_d;
  logic              pend_q,  pend_d;
  logic              rd_q,    rd_d;

  logic              req_disp;
  logic              req_wr;
  logic [1:0]        gnt_oh;
  fb_gnt_e           gnt;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_in_range;

  // Requests are masked during reset so every strobe and address reads 0.
  always_comb begin
    req_disp = ~rst & ~dvi_fifo_full;
    req_wr   = ~rst & ((state_q == CLEAR) | ((state_q == DRAW) & rast_pixel_rdy));
  end

  fb_rr_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_disp (req_disp),
    .req_wr   (req_wr),
    .gnt_oh   (gnt_oh)
  );

  // Linear pixel address and on-screen test for the incoming raster pixel.
  always_comb begin
    gnt          = gnt_encode(gnt_oh);
    pix_addr     = ADDR_W'(rast_height) * ADDR_W'(H_RES) + ADDR_W'(rast_width);
    pix_in_range = (rast_width < H_LIM) && (rast_height < V_LIM);
  end

  // Drive the memory port from the grant and compute all next-state values.
  always_comb begin
    state_d             = state_q;
    front_d             = front_q;
    scan_d              = scan_q;
    clr_d               = clr_q;
    pend_d              = pend_q;
    rd_d                = 1'b0;
    mem_addr            = '0;
    mem_we              = 1'b0;
    mem_wdata           = '0;
    read_rast_pixel_rdy = 1'b0;

    case (gnt)
      GNT_DISP: begin
        mem_addr = {front_q, scan_q};
        rd_d     = 1'b1;
        scan_d   = (scan_q == PIX_LAST) ? '0 : scan_q + ONE_A;
      end
      GNT_WR: begin
        if (state_q == CLEAR) begin
          mem_addr  = {~front_q, clr_q};
          mem_we    = 1'b1;
          mem_wdata = CLEAR_COLOR;
        end else begin
          // Off-screen pixels are consumed but never written.
          read_rast_pixel_rdy = 1'b1;
          if (pix_in_range) begin
            mem_addr  = {~front_q, pix_addr};
            mem_we    = 1'b1;
            mem_wdata = rast_color_input;
          end else begin
            mem_addr  = '0;
          end
        end
      end
      default: begin
        mem_addr = '0;
      end
    endcase

    case (state_q)
      CLEAR: begin
        if (next_frame_switch) begin
          pend_d = 1'b1;
        end else begin
          pend_d = pend_q;
        end
        if (gnt == GNT_WR) begin
          if (clr_q == PIX_LAST) begin
            clr_d   = '0;
            state_d = DRAW;
          end else begin
            clr_d   = clr_q + ONE_A;
          end
        end else begin
          clr_d = clr_q;
        end
      end
      DRAW: begin
        if (rast_done && next_frame_switch) begin
          pend_d  = 1'b0;
          state_d = WAIT_SCAN;
        end else if (rast_done) begin
          state_d = DONE;
        end else if (next_frame_switch) begin
          pend_d  = 1'b1;
        end else begin
          state_d = DRAW;
        end
      end
      DONE: begin
        if (pend_q || next_frame_switch) begin
          pend_d  = 1'b0;
          state_d = WAIT_SCAN;
        end else begin
          state_d = DONE;
        end
      end
      WAIT_SCAN: begin
        if (next_frame_switch) begin
          pend_d = 1'b1;
        end else begin
          pend_d = pend_q;
        end
        // Swap only when the display has just fetched the last pixel.
        if ((gnt == GNT_DISP) && (scan_q == PIX_LAST)) begin
          front_d = ~front_q;
          state_d = CLEAR;
        end else begin
          state_d = WAIT_SCAN;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Scheduler state; reset abandons any in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      front_q <= 1'b0;
      scan_q  <= '0;
      clr_q   <= '0;
      pend_q  <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      scan_q  <= scan_d;
      clr_q   <= clr_d;
      pend_q  <= pend_d;
      rd_q    <= rd_d;
    end
  end

  // Read data returns one cycle after issue and is pushed straight to the FIFO.
  always_comb begin
    dvi_fifo_write_enable = rd_q;
    dvi_color_out         = rd_q ? mem_rdata : '0;
    front_buffer          = front_q;
  end

endmodule
